pc_fetch_unit: RTL and testbench

- Owns the program counter for the RISC-V core.
- Issues instruction-memory read requests over a valid/ready handshake and returns each response to decode over a second valid/ready handshake.
- Accepts branch/jump redirects from execute at any time and discards stale responses.
- One request outstanding at most; sequential next PC is PC+4.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/pc_fetch_unit_pc_incr.sv | 13 +
 rtl/pc_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: widths, reset PC default, fetch FSM states
// and the alignment helper used when taking redirects.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_INCR          = 4;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    // Only the two low address bits decide word alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_incr.sv
// Sequential next-PC adder; wraps modulo 2^XLEN.
module pc_incr
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_pc_next
);

    assign o_pc_next = i_pc + XLEN'(PC_INCR);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter owner: one outstanding imem fetch, decode handshake, redirects.
// state   | meaning
// S_REQ   | request for pc offered to imem
// S_WAIT  | request accepted, response pending
// S_HOLD  | instruction (or fault) presented to decode
// S_DRAIN | stale response still outstanding, discard it
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            inst_ready,
    output logic [XLEN-1:0] pc_out
);

    fetch_state_t    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt, w_pc_plus4;
    logic [XLEN-1:0] r_inst_data, w_inst_data_nxt;
    logic [XLEN-1:0] r_inst_pc, w_inst_pc_nxt;
    logic            r_inst_valid, w_inst_valid_nxt;
    logic            r_inst_fault, w_inst_fault_nxt;
    logic            r_pend_fault, w_pend_fault_nxt;
    logic            w_req_valid, w_req_fire, w_outstanding;

    pc_incr #(.XLEN(XLEN)) u_pc_incr (
        .i_pc      (r_pc),
        .o_pc_next (w_pc_plus4)
    );

    assign w_req_valid = rst_n && (r_state == S_REQ);
    assign w_req_fire  = w_req_valid && imem_req_ready;

    // A fetch is still in flight after this edge unless its response lands now.
    assign w_outstanding = ((r_state == S_REQ) && w_req_fire) ||
                           (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_rsp_valid);

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_valid_nxt = r_inst_valid;
        w_inst_data_nxt  = r_inst_data;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_fault_nxt = r_inst_fault;
        w_pend_fault_nxt = r_pend_fault;
        if (redirect_valid) begin
            w_pc_nxt         = redirect_pc;
            w_inst_valid_nxt = 1'b0;
            w_pend_fault_nxt = 1'b0;
            if (w_outstanding) begin
                w_state_nxt      = S_DRAIN;
                w_pend_fault_nxt = is_misaligned(redirect_pc[1:0]);
            end else if (is_misaligned(redirect_pc[1:0])) begin
                w_state_nxt      = S_HOLD;
                w_inst_valid_nxt = 1'b1;
                w_inst_data_nxt  = '0;
                w_inst_pc_nxt    = redirect_pc;
                w_inst_fault_nxt = 1'b1;
            end else begin
                w_state_nxt = S_REQ;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_fire) w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        w_state_nxt      = S_HOLD;
                        w_inst_valid_nxt = 1'b1;
                        w_inst_data_nxt  = imem_rsp_data;
                        w_inst_pc_nxt    = r_pc;
                        w_inst_fault_nxt = imem_rsp_err;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        w_state_nxt      = S_REQ;
                        w_pc_nxt         = w_pc_plus4;
                        w_inst_valid_nxt = 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (imem_rsp_valid) begin
                        w_pend_fault_nxt = 1'b0;
                        if (r_pend_fault) begin
                            w_state_nxt      = S_HOLD;
                            w_inst_valid_nxt = 1'b1;
                            w_inst_data_nxt  = '0;
                            w_inst_pc_nxt    = r_pc;
                            w_inst_fault_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_REQ;
                        end
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst_data  <= '0;
            r_inst_pc    <= '0;
            r_inst_fault <= 1'b0;
            r_pend_fault <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst_data  <= w_inst_data_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_fault <= w_inst_fault_nxt;
            r_pend_fault <= w_pend_fault_nxt;
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst_data      = r_inst_data;
    assign inst_pc        = r_inst_pc;
    assign inst_fault     = r_inst_fault;
    assign pc_out         = r_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: transaction-level fetch model compared every cycle,
// a latency-programmable instruction memory, and directed scenarios.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_ready;
    logic [31:0] pc_out;

    pc_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .inst_ready     (inst_ready),
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return a ^ 32'h1357_0000;
    endfunction

    // Instruction memory: answers each accepted request after mem_lat idle cycles.
    int          mem_lat  = 0;
    bit          err_en   = 1'b0;
    logic [31:0] err_addr = 32'h0;
    bit          mem_wait = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            if (!rst_n) begin
                mem_wait = 1'b0;
            end else begin
                if (mem_wait) begin
                    if (mem_cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_word(mem_addr);
                        imem_rsp_err   = err_en && (mem_addr == err_addr);
                        mem_wait       = 1'b0;
                    end else begin
                        mem_cnt--;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    mem_wait = 1'b1;
                    mem_cnt  = mem_lat;
                    mem_addr = imem_req_addr;
                end
            end
        end
    end

    // Reference model: tracks whether a fetch is in flight, whether its answer
    // is wanted, and what (if anything) is being offered to decode.
    logic [31:0] m_pc = RST_PC;
    bit          m_out, m_stale, m_pf, m_held;
    logic [31:0] m_data, m_ipc;
    bit          m_fault;

    initial begin
        bit acc, rsp, busy, mis;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_pc = RST_PC; m_out = 0; m_stale = 0; m_pf = 0;
                m_held = 0; m_data = 0; m_ipc = 0; m_fault = 0;
            end else begin
                acc = !m_out && !m_held && imem_req_ready;
                rsp = imem_rsp_valid && m_out;
                if (redirect_valid) begin
                    mis     = redirect_pc[1:0] != 2'b00;
                    busy    = (m_out && !rsp) || acc;
                    m_held  = 0;
                    m_pc    = redirect_pc;
                    m_out   = busy;
                    m_stale = busy;
                    m_pf    = busy && mis;
                    if (!busy && mis) begin
                        m_held = 1; m_data = 0; m_ipc = redirect_pc; m_fault = 1;
                    end
                end else if (acc) begin
                    m_out = 1; m_stale = 0;
                end else if (rsp) begin
                    m_out = 0;
                    if (!m_stale) begin
                        m_held = 1; m_data = imem_rsp_data; m_ipc = m_pc; m_fault = imem_rsp_err;
                    end else if (m_pf) begin
                        m_held = 1; m_data = 0; m_ipc = m_pc; m_fault = 1;
                    end
                    m_stale = 0; m_pf = 0;
                end else if (m_held && inst_ready) begin
                    m_held = 0;
                    m_pc   = m_pc + 32'd4;
                end
            end
        end
    end

    initial begin
        logic exp_req;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_req = rst_n && !m_out && !m_held;
                check("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_req});
                if (exp_req) check("req_addr", imem_req_addr, m_pc);
                check("pc_out", pc_out, m_pc);
                check("inst_valid", {31'h0, inst_valid}, {31'h0, m_held});
                if (m_held) begin
                    check("inst_data", inst_data, m_data);
                    check("inst_pc", inst_pc, m_ipc);
                    check("inst_fault", {31'h0, inst_fault}, {31'h0, m_fault});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_inst_fault", {31'h0, inst_fault}, 32'h0);

        // Zero-wait memory, decode always ready: 3-cycle cadence.
        rst_n = 1'b1; #1;
        check("t1_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("t1_req_addr", imem_req_addr, 32'h0);
        tick();
        check("t1_wait_no_req", {31'h0, imem_req_valid}, 32'h0);
        tick();
        check("t1_inst_valid", {31'h0, inst_valid}, 32'h1);
        check("t1_inst_data", inst_data, 32'h0050_0093);
        check("t1_inst_pc", inst_pc, 32'h0);
        tick();
        check("t1_next_addr", imem_req_addr, 32'h4);
        check("t1_next_valid", {31'h0, imem_req_valid}, 32'h1);

        // Decode stalls for 5 cycles.
        inst_ready = 1'b0;
        tick(); tick();
        check("t2_inst_pc", inst_pc, 32'h4);
        check("t2_inst_data", inst_data, 32'h1357_0004);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_pc", inst_pc, 32'h4);
            check("t2_stall_req", {31'h0, imem_req_valid}, 32'h0);
            check("t2_stall_pcout", pc_out, 32'h4);
        end

        // Bus error on the fetch of 0x8.
        err_en = 1'b1; err_addr = 32'h8; inst_ready = 1'b1;
        tick();
        check("t5_req_addr", imem_req_addr, 32'h8);
        tick(); tick();
        check("t5_fault", {31'h0, inst_fault}, 32'h1);
        check("t5_inst_pc", inst_pc, 32'h8);
        tick();
        check("t5_next_addr", imem_req_addr, 32'hC);
        err_en = 1'b0;

        // Redirect while waiting; late response must be dropped.
        mem_lat = 2;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("t3_drain_req", {31'h0, imem_req_valid}, 32'h0);
        check("t3_pc_out", pc_out, 32'h100);
        tick();
        check("t3_drain_req2", {31'h0, imem_req_valid}, 32'h0);
        tick();
        check("t3_req_addr", imem_req_addr, 32'h100);
        check("t3_no_old", {31'h0, inst_valid}, 32'h0);
        mem_lat = 0;
        tick(); tick();
        check("t3_inst_pc", inst_pc, 32'h100);
        check("t3_inst_data", inst_data, 32'h1357_0100);
        tick();
        check("t3_next_addr", imem_req_addr, 32'h104);

        // Misaligned redirect while the request is not accepted.
        imem_req_ready = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        check("t4_valid", {31'h0, inst_valid}, 32'h1);
        check("t4_fault", {31'h0, inst_fault}, 32'h1);
        check("t4_inst_pc", inst_pc, 32'h102);
        check("t4_inst_data", inst_data, 32'h0);
        check("t4_no_req", {31'h0, imem_req_valid}, 32'h0);
        tick();

        // Redirect out of HOLD to the top word, then wrap.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0; inst_ready = 1'b1;
        check("t6_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        check("t6_inst_valid", {31'h0, inst_valid}, 32'h0);
        tick(); tick();
        check("t6_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        check("t6_wrap_addr", imem_req_addr, 32'h0);
        check("t6_wrap_pcout", pc_out, 32'h0);

        // Redirect in the same cycle the request is accepted.
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        check("t7_drain", {31'h0, imem_req_valid}, 32'h0);
        tick();
        check("t7_req_addr", imem_req_addr, 32'h300);
        check("t7_no_inst", {31'h0, inst_valid}, 32'h0);

        // Misaligned redirect with a fetch in flight: drain, then fault.
        mem_lat = 1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h206;
        tick();
        redirect_valid = 1'b0;
        check("t8_drain", {31'h0, imem_req_valid}, 32'h0);
        tick();
        check("t8_fault", {31'h0, inst_fault}, 32'h1);
        check("t8_inst_pc", inst_pc, 32'h206);
        check("t8_valid", {31'h0, inst_valid}, 32'h1);
        mem_lat = 0;
        tick();
        check("t8_next_addr", imem_req_addr, 32'h20A);

        // Redirect while the response arrives: answer dropped, go straight to REQ.
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick();
        redirect_valid = 1'b0;
        check("t9_req_addr", imem_req_addr, 32'h500);
        check("t9_no_inst", {31'h0, inst_valid}, 32'h0);

        // Reset mid-transaction.
        mem_lat = 3;
        tick();
        rst_n = 1'b0; #1;
        check("t10_req_comb", {31'h0, imem_req_valid}, 32'h0);
        tick();
        check("t10_pc_out", pc_out, RST_PC);
        check("t10_inst_valid", {31'h0, inst_valid}, 32'h0);
        rst_n = 1'b1; mem_lat = 0; #1;
        check("t10_req_addr", imem_req_addr, RST_PC);
        tick(); tick();
        check("t10_inst_data", inst_data, 32'h0050_0093);
        repeat (4) tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
